// File: rtl/fir_out_packer.sv
// Packs LANES consecutive FIR samples into one wide word and streams the words out
// through a small FWFT FIFO as an AXI4-Stream master. Words that find the FIFO full are dropped and counted.
module fir_out_packer #(
  parameter int DATA_W      = 16,
  parameter int LANES       = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic [DATA_W*LANES-1:0]           m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              clear_ovf,
  output logic [15:0]                       ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int WORD_W = DATA_W * LANES;
  localparam int LNW    = $clog2(LANES);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int LW     = PW + 1;
  localparam int FW_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [LNW-1:0]  LANE_LAST  = LNW'(LANES - 1);
  localparam logic [LW-1:0]   DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [FW_W-1:0] FRAME_LAST = FW_W'(FRAME_WORDS - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [LNW-1:0]    lane_p0;
  logic [WORD_W-1:0] word_p0;
  logic [WORD_W-1:0] word_full;
  logic              word_done;
  logic              push;
  logic              pop;
  logic              drop;
  logic              frame_last;

  logic [FW_W-1:0]   frame_p1;
  logic [PW-1:0]     wr_ptr_p1;
  logic [PW-1:0]     rd_ptr_p1;
  logic [LW-1:0]     level_p1;
  logic [15:0]       ovf_p1;
  logic [WORD_W:0]   mem_p1 [FIFO_DEPTH];
  logic [WORD_W:0]   head;

  // p0: lane packing; the completed word is assembled combinationally with the final sample
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_p0 <= '0;
    end else if (in_valid) begin
      lane_p0 <= (lane_p0 == LANE_LAST) ? '0 : lane_p0 + LNW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      word_p0[lane_p0*DATA_W +: DATA_W] <= in_data;
    end
  end

  always_comb begin
    word_full = word_p0;
    word_full[(LANES-1)*DATA_W +: DATA_W] = in_data;
  end

  assign m_axis_tvalid = (level_p1 != '0);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign word_done  = ~rst & in_valid & (lane_p0 == LANE_LAST);
  assign push       = word_done & ((level_p1 < DEPTH_L) | pop);
  assign drop       = word_done & ~push;
  assign frame_last = (frame_p1 == FRAME_LAST);

  // p1: FIFO storage, frame marking and drop accounting
  always_ff @(posedge clk) begin
    if (push) begin
      mem_p1[wr_ptr_p1] <= {frame_last, word_full};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      level_p1  <= '0;
      frame_p1  <= '0;
    end else begin
      if (push) begin
        wr_ptr_p1 <= wr_ptr_p1 + PW'(1);
        frame_p1  <= frame_last ? '0 : frame_p1 + FW_W'(1);
      end
      if (pop) begin
        rd_ptr_p1 <= rd_ptr_p1 + PW'(1);
      end
      if (push && !pop) begin
        level_p1 <= level_p1 + LW'(1);
      end else if (!push && pop) begin
        level_p1 <= level_p1 - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p1 <= '0;
    end else if (clear_ovf) begin
      ovf_p1 <= '0;
    end else if (drop) begin
      ovf_p1 <= sat_inc16(ovf_p1);
    end
  end

  // Storage is not reset, so the head is masked to zero whenever nothing is stored
  assign head         = mem_p1[rd_ptr_p1];
  assign m_axis_tdata = m_axis_tvalid ? head[WORD_W-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & head[WORD_W];
  assign ovf_cnt      = ovf_p1;
  assign fifo_level   = level_p1;

endmodule

// File: doc/fir_out_packer.md
# fir_out_packer

Downstream stage of `fir_top`: accepts the FIR's free-running 16-bit output samples, packs `LANES` consecutive samples into one wide word, buffers words in a small first-word-fall-through FIFO, and presents them as an AXI4-Stream master toward the DDR4 DMA write path. The FIR has no backpressure, so the block absorbs DMA stalls in its FIFO. It drops whole words when the FIFO is full and counts every drop.

## Interface
- `DATA_W`, 16, sample width from `fir_top.data_out`
- `LANES`, 4, samples per output word (≥2)
- `FIFO_DEPTH`, 16, words of buffering (power of 2, ≥2)
- `FRAME_WORDS`, 256, accepted words per frame; `m_axis_tlast` marks the last word of each frame (≥1)

Ports:
- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  sample strobe from the FIR stage
- `in_data`  in  DATA_W  FIR output sample
- `m_axis_tdata`  out  DATA_W*LANES  packed word
- `m_axis_tvalid`  out  1  word available
- `m_axis_tready`  in  1  DMA accepts the word
- `m_axis_tlast`  out  1  last word of the frame
- `clear_ovf`  in  1  single-cycle pulse that zeroes `ovf_cnt`
- `ovf_cnt`  out  16  dropped-word count, saturating at 0xFFFF
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  words currently stored

## Operation
- Packer:
  - Lane counter runs 0..LANES-1 and advances only when `in_valid`=1.
  - The sample is written at bits `[lane*DATA_W +: DATA_W]`; the first sample lands in the least-significant lane.
  - On a valid sample with lane = LANES-1 the word is complete, and the counter wraps to 0 in the same cycle.
- Push decision, made in the cycle the word completes:
  - Accepted if `fifo_level` < FIFO_DEPTH, or if a pop happens in the same cycle (`tvalid & tready`).
  - Otherwise dropped: `ovf_cnt` increments (saturating) and the lane counter still wraps. Packing never stalls or misaligns.
- Frame counter:
  - Counts accepted words only, from 0 to FRAME_WORDS-1.
  - The word accepted at count FRAME_WORDS-1 is stored with tlast=1, and the counter wraps to 0.
  - Dropped words do not advance the counter, so every frame delivers exactly FRAME_WORDS words.
- FIFO:
  - Entry is {tlast, tdata}; storage is circular with wrapping read/write pointers.
  - `m_axis_tvalid` = (level ≠ 0). `tdata`/`tlast` show the head entry.
  - Pop occurs on `tvalid & tready`.
  - `fifo_level` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- AXI rule: once `tvalid` is high, `tdata`/`tlast` stay stable until the handshake.
- `ovf_cnt`:
  - `clear_ovf` has priority over an increment in the same cycle; the result is 0.
  - Held at 0xFFFF once saturated.
- Reset (`rst`=1 at a rising edge), including mid-word or mid-frame:
  - Lane counter, frame counter, pointers, `fifo_level` and `ovf_cnt` go to 0, and the partial word is discarded.
  - Outputs after reset: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `ovf_cnt`=0, `fifo_level`=0.
  - `in_valid` is ignored while `rst`=1.

## Timing
- The word completes on edge E, when the last lane is sampled. `m_axis_tvalid` is high in the cycle after E, provided the FIFO was empty.
- Latency from first sample to tvalid is therefore LANES cycles at full input rate.
- Throughput:
  - One pop per cycle while `tready`=1.
  - Sustained input of up to one sample per cycle never overflows while `tready` stays high.
- `fifo_level`, `ovf_cnt` and `m_axis_tvalid` are registered and update on the edge after the event.
- `tready` combinationally gates only the pop enable; there is no combinational path from `in_*` to `m_axis_*`.

## Test plan
- **Ramp packing:** `in_data`=0,1,2,… with `in_valid`=1 every cycle and `tready`=1. Required: first word 0x0003_0002_0001_0000, second word 0x0007_0006_0005_0004, first tvalid 4 cycles after the first sample, `ovf_cnt`=0.
- **Gapped input:** `in_valid` toggles every other cycle with samples 0xA0..0xA3. Required: one word 0x00A3_00A2_00A1_00A0; lane alignment is unaffected by the gaps.
- **Backpressure/overflow:** hold `tready`=0 with continuous input for 20 words (DEPTH=16). Required:
  - `fifo_level`=16 and `ovf_cnt`=4.
  - After releasing `tready`, exactly 16 words drain in order, and they are words 0–15.
- **Frame marking:** FRAME_WORDS=4, continuous input and `tready`=1. Required: tlast on output words 3, 7, 11. With 2 words dropped mid-frame, tlast still falls on every 4th delivered word.
- **Simultaneous events:**
  - At `fifo_level`=16, a push coinciding with a pop. Required: the word is accepted, the level stays 16, and `ovf_cnt` is unchanged.
  - `clear_ovf` asserted together with a drop. Required: `ovf_cnt`=0.
  - `ovf_cnt` at 0xFFFF with a further drop. Required: it stays at 0xFFFF.
- **Reset mid-operation:** assert `rst` after 2 lanes are filled and the FIFO holds 5 words. Required:
  - The next cycle shows tvalid=0, tdata=0, level=0.
  - The sample following reset release lands in lane 0.
